timer_digit_entry: RTL and testbench
====================================

# timer_digit_entry

Keypad digit accumulator for the microwave timer-entry path. Consumes the BCD key code and active-low key-valid line from the 10-key priority encoder. Synchronises and debounces each press, accepts one digit per press, and shifts accepted digits right-to-left into a 4-digit MM:SS BCD entry register. The countdown/display logic reads that register.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a press, and to accept a release; legal range 1..255.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `digit`  in  4  BCD key code from encoder; may be asynchronous.
- `key_n`  in  1  encoder Cn; 0 = key pressed and encoder enabled; may be asynchronous.
- `clear`  in  1  synchronous clear of the entry, from the cancel key.
- `lock`  in  1  oven running; key entry inhibited.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  entry register, BCD.
- `digit_count`  out  3  digits entered, 0..4.
- `entry_valid`  out  1  high when `digit_count` != 0.
- `key_ack`  out  1  one-cycle pulse per accepted digit.
- `key_err`  out  1  one-cycle pulse per rejected press.

## Operation
- **Reset:** all outputs 0. Synchroniser flops reset to `key_n`=1 and `digit`=0. FSM is in IDLE and the counter is 0.
- **Synchroniser:** `key_n` and `digit` each pass through 2 flops. The FSM sees only synchronised values `kn_s` and `dg_s`.
- **FSM: IDLE → DEBOUNCE → ACCEPT → RELEASE → IDLE.**
  - IDLE: when `kn_s`=0, latch `dg_s` into `cand`, set cnt=1, go to DEBOUNCE.
  - DEBOUNCE: if `kn_s`=1 or `dg_s`!=`cand`, go to IDLE (press discarded, no pulse). Otherwise increment cnt. When cnt reaches `DEBOUNCE_CYCLES`, go to ACCEPT.
  - ACCEPT (one cycle): evaluate the press, then go to RELEASE with cnt=0.
  - RELEASE: cnt counts consecutive `kn_s`=1 samples and resets to 0 on any `kn_s`=0. At `DEBOUNCE_CYCLES` go to IDLE. A held key therefore yields exactly one digit.
- **Press evaluation in ACCEPT**, first match wins:
  1. `lock`=1: ignore; no pulse.
  2. `cand` > 9: reject; `key_err`.
  3. `digit_count`=4: reject; `key_err`.
  4. Range check fails (see Configuration): reject; `key_err`.
  5. Otherwise accept:
     - Shift `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`cand`.
     - `digit_count`+1.
     - Pulse `key_ack`.
- **Leading zeros:** a leading 0 is accepted and counted.
- **`clear`:**
  - Highest priority; overrides `lock`.
  - Zeroes the four digits and `digit_count`.
  - Forces the FSM to RELEASE with cnt=0, so a key held during clear is never accepted.
  - No pulses.
- **`lock` outside ACCEPT:** the FSM runs normally; only the register update is inhibited.

## Timing
- Let t0 be the first edge at which `key_n`=0 is sampled, with `digit` stable from before t0 through the acceptance edge.
  - `kn_s`=0 from t0+2.
  - ACCEPT is entered at edge t0+1+`DEBOUNCE_CYCLES`.
  - Register, `digit_count`, and `key_ack`/`key_err` update at edge t0+2+`DEBOUNCE_CYCLES` (t0+6 at default).
  - Pulses are high for exactly one cycle.
- After `key_n` returns to 1, the next press can start debouncing no earlier than 2+`DEBOUNCE_CYCLES` cycles later.
- `clear` asserted in the same cycle as ACCEPT: clear wins, no shift, no pulse.
- `rst` mid-press: immediate return to reset state. A still-held key is then accepted as a new press, because reset leaves the FSM in IDLE.
- `key_ack` and `key_err` are never high in the same cycle.

## Configuration
- **`SEC_RANGE_CHECK_EN` defined:** an accept that would move `sec_ones` > 5 into `sec_tens` is rejected with `key_err` and leaves the register unchanged. This keeps the seconds field within 00..59.
- **`SEC_RANGE_CHECK_EN` undefined:** no range check; any BCD digit shifts in.
- Both builds keep the identical port list.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4; each press is held 10 cycles and released 10 cycles unless stated.
- Reset with `key_n`=0 and `digit`=7 → all outputs 0; after `rst` falls, 7 is accepted with `key_ack` 6 edges later.
- Press 1, 2, 3, 0 → final register min_tens=1, min_ones=2, sec_tens=3, sec_ones=0; `digit_count`=4; `entry_valid`=1; exactly 4 `key_ack` pulses, each at t0+6.
- Bouncing `key_n` (low 3 cycles / high 1 cycle, ×5), then high → no `key_ack`, no `key_err`, register unchanged.
- Fifth press 7 after four digits → one `key_err` pulse, register and count unchanged. Press held 50 cycles → still one pulse only.
- `clear` pulse while 4 is held after entering 5 → all zero and count 0; the held 4 is not accepted until released and pressed again. Entry with `lock`=1 → no change, no pulse.
- Press 7 then 8:
  - With `SEC_RANGE_CHECK_EN`: 8 rejected with `key_err`; sec_ones=7.
  - Without: sec_tens=7, sec_ones=8, two acks.

Source files
------------

// File: rtl/timer_digit_entry.sv
// timer_digit_entry
//   Keypad digit accumulator for the microwave timer-entry path. Each key
//   press from the 10-key priority encoder is synchronised and debounced. One
//   digit is accepted per press and shifted right-to-left into a 4-digit MM:SS
//   BCD entry register.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a press and
//                    to accept a release (1..255)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   digit[3:0]   BCD key code from the encoder (may be asynchronous)
//   key_n        encoder Cn, 0 = key pressed (may be asynchronous)
//   clear        synchronous clear of the entry (cancel key)
//   lock         oven running; key entry inhibited
//   min_tens, min_ones, sec_tens, sec_ones [3:0]  entry register, BCD
//   digit_count[2:0]  digits entered, 0..4
//   entry_valid  high when digit_count != 0
//   key_ack      one-cycle pulse per accepted digit
//   key_err      one-cycle pulse per rejected press
//
// Build option
//   SEC_RANGE_CHECK_EN  when defined, an accept that would move a sec_ones
//                       value above 5 into sec_tens is rejected with key_err.
//                       This keeps the seconds field within 00..59.
module timer_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       key_n,
  input  logic       clear,
  input  logic       lock,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       entry_valid,
  output logic       key_ack,
  output logic       key_err
);

  localparam logic [7:0] CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam bit         ONE_CYCLE = (DEBOUNCE_CYCLES == 1);
`ifdef SEC_RANGE_CHECK_EN
  localparam bit         RANGE_EN  = 1'b1;
`else
  localparam bit         RANGE_EN  = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, RELEASE} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] cand;
  logic       kn_p0, kn_s;
  logic [3:0] dg_p0, dg_s;
  logic       range_fail;

  // An accepted digit moves sec_ones into sec_tens; that digit must be 0..5.
  assign range_fail  = RANGE_EN && (digit_count != 3'd0) && (sec_ones > 4'd5);
  assign entry_valid = (digit_count != 3'd0);

  // Stage p0 -> s: two-flop synchroniser for the asynchronous encoder lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kn_p0 <= 1'b1;
      kn_s  <= 1'b1;
      dg_p0 <= 4'd0;
      dg_s  <= 4'd0;
    end else begin
      kn_p0 <= key_n;
      kn_s  <= kn_p0;
      dg_p0 <= digit;
      dg_s  <= dg_p0;
    end
  end

  // Debounce FSM and entry register, fed only by the synchronised lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      cand        <= 4'd0;
      min_tens    <= 4'd0;
      min_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      digit_count <= 3'd0;
      key_ack     <= 1'b0;
      key_err     <= 1'b0;
    end else begin
      key_ack <= 1'b0;
      key_err <= 1'b0;
      if (clear) begin
        // Parking in RELEASE means a key held through clear must be lifted
        // before it can count again.
        min_tens    <= 4'd0;
        min_ones    <= 4'd0;
        sec_tens    <= 4'd0;
        sec_ones    <= 4'd0;
        digit_count <= 3'd0;
        state       <= RELEASE;
        cnt         <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (!kn_s) begin
              cand  <= dg_s;
              cnt   <= 8'd1;
              state <= ONE_CYCLE ? ACCEPT : DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (kn_s || (dg_s != cand)) begin
              state <= IDLE;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
              if (cnt >= CNT_LAST) state <= ACCEPT;
            end
          end
          ACCEPT: begin
            state <= RELEASE;
            cnt   <= 8'd0;
            if (!lock) begin
              if ((cand > 4'd9) || (digit_count == 3'd4) || range_fail) begin
                key_err <= 1'b1;
              end else begin
                min_tens    <= min_ones;
                min_ones    <= sec_tens;
                sec_tens    <= sec_ones;
                sec_ones    <= cand;
                digit_count <= digit_count + 3'd1;
                key_ack     <= 1'b1;
              end
            end
          end
          RELEASE: begin
            // Only an unbroken run of released samples returns to IDLE.
            if (!kn_s) begin
              cnt <= 8'd0;
            end else if (cnt >= CNT_LAST) begin
              state <= IDLE;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_digit_entry.sv
// Testbench for timer_digit_entry (DEBOUNCE_CYCLES = 4).
// The reference model keeps the entered digits as a queue of at most four
// values; the expected register is the last four entries, zero padded.
module tb_timer_digit_entry;

  logic       clk = 1'b0;
  logic       rst, key_n, clear, lock;
  logic [3:0] digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_count;
  logic       entry_valid, key_ack, key_err;

  int errors = 0;
  int checks = 0;
  int mq[$];

  // Acceptance edge is t0+2+DEBOUNCE_CYCLES; step i observes edge t0+i-1.
  localparam int PULSE_STEP = 7;

  timer_digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .digit(digit), .key_n(key_n), .clear(clear),
    .lock(lock), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .digit_count(digit_count),
    .entry_valid(entry_valid), .key_ack(key_ack), .key_err(key_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_dig(input int pos);
    if (mq.size() > pos) return 4'(mq[mq.size() - 1 - pos]);
    return 4'd0;
  endfunction

  function automatic logic [15:0] exp_word();
    return {exp_dig(3), exp_dig(2), exp_dig(1), exp_dig(0)};
  endfunction

  // Outcome of one press: 0 = no pulse, 1 = ack, 2 = err.
  function automatic int model_press(input int d, input bit lk, input bit clr);
    if (clr) begin
      mq.delete();
      return 0;
    end
    if (lk) return 0;
    if (d > 9) return 2;
    if (mq.size() == 4) return 2;
`ifdef SEC_RANGE_CHECK_EN
    if (mq.size() > 0 && mq[mq.size() - 1] > 5) return 2;
`endif
    mq.push_back(d);
    return 1;
  endfunction

  // Holds the key for 'hold' cycles then releases it for 'rel' cycles.
  // A nonzero clr_step pulses clear so that it is sampled at edge t0+clr_step.
  task automatic drive_press(input logic [3:0] d, input int hold, input int rel,
                             input int clr_step, output int acks, output int errs,
                             output int at, output int both);
    acks = 0; errs = 0; at = -1; both = 0;
    digit = d;
    key_n = 1'b0;
    for (int i = 1; i <= hold + rel; i++) begin
      if (i == hold + 1) key_n = 1'b1;
      if (clr_step != 0 && i == clr_step + 1) clear = 1'b1;
      if (clr_step != 0 && i == clr_step + 2) clear = 1'b0;
      step();
      if (key_ack) begin acks++; if (at < 0) at = i; end
      if (key_err) begin errs++; if (at < 0) at = i; end
      if (key_ack && key_err) both++;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (6) step();
    mq.delete();
  endtask

  task automatic test_reset();
    int acks, at;
    rst = 1'b1; key_n = 1'b0; digit = 4'd7; clear = 1'b0; lock = 1'b0;
    repeat (3) step();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones, digit_count, entry_valid, key_ack, key_err} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {min_tens, min_ones, sec_tens, sec_ones, digit_count, entry_valid, key_ack, key_err});
    end
    rst = 1'b0;
    acks = 0; at = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (key_ack) begin acks++; if (at < 0) at = i; end
    end
    key_n = 1'b1;
    repeat (10) step();
    mq.delete();
    void'(model_press(7, 1'b0, 1'b0));
    checks++;
    if (acks !== 1 || at !== PULSE_STEP) begin
      errors++;
      $display("FAIL reset_held_key: acks=%0d at step %0d, required 1 at step %0d", acks, at, PULSE_STEP);
    end
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones, digit_count} !== {exp_word(), 3'(mq.size())}) begin
      errors++;
      $display("FAIL reset_held_regs: got %h/%0d required %h/%0d",
               {min_tens, min_ones, sec_tens, sec_ones}, digit_count, exp_word(), mq.size());
    end
  endtask

  task automatic test_sequence();
    int acks, errs, at, both, r;
    int seq[4] = '{1, 2, 3, 0};
    int tot_acks = 0;
    do_clear();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones, digit_count, entry_valid} !== 20'd0) begin
      errors++;
      $display("FAIL clear_state: got %h required 0", {min_tens, min_ones, sec_tens, sec_ones, digit_count});
    end
    foreach (seq[k]) begin
      r = model_press(seq[k], 1'b0, 1'b0);
      drive_press(4'(seq[k]), 10, 10, 0, acks, errs, at, both);
      tot_acks += acks;
      checks++;
      if (acks !== (r == 1 ? 1 : 0) || errs !== 0 || at !== PULSE_STEP) begin
        errors++;
        $display("FAIL seq_press%0d: ack=%0d err=%0d at=%0d required ack=1 err=0 at=%0d",
                 k, acks, errs, at, PULSE_STEP);
      end
    end
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h1230 || digit_count !== 3'd4 || entry_valid !== 1'b1 || tot_acks !== 4) begin
      errors++;
      $display("FAIL seq_final: got %h cnt=%0d ev=%b acks=%0d required 1230 cnt=4 ev=1 acks=4",
               {min_tens, min_ones, sec_tens, sec_ones}, digit_count, entry_valid, tot_acks);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    digit = 4'd5;
    for (int b = 0; b < 5; b++) begin
      key_n = 1'b0;
      repeat (3) begin step(); if (key_ack || key_err) pulses++; end
      key_n = 1'b1;
      step(); if (key_ack || key_err) pulses++;
    end
    repeat (12) begin step(); if (key_ack || key_err) pulses++; end
    checks++;
    if (pulses !== 0 || {min_tens, min_ones, sec_tens, sec_ones} !== exp_word()) begin
      errors++;
      $display("FAIL bounce: pulses=%0d regs=%h required 0 and %h",
               pulses, {min_tens, min_ones, sec_tens, sec_ones}, exp_word());
    end
  endtask

  task automatic test_full();
    int acks, errs, at, both, r;
    r = model_press(7, 1'b0, 1'b0);
    drive_press(4'd7, 50, 10, 0, acks, errs, at, both);
    checks++;
    if (r !== 2 || acks !== 0 || errs !== 1 || at !== PULSE_STEP) begin
      errors++;
      $display("FAIL full_reject: ack=%0d err=%0d at=%0d required ack=0 err=1 at=%0d", acks, errs, at, PULSE_STEP);
    end
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones, digit_count} !== {exp_word(), 3'(mq.size())}) begin
      errors++;
      $display("FAIL full_regs: got %h/%0d required %h/%0d",
               {min_tens, min_ones, sec_tens, sec_ones}, digit_count, exp_word(), mq.size());
    end
  endtask

  task automatic test_clear_held();
    int acks, errs, at, both;
    do_clear();
    void'(model_press(5, 1'b0, 1'b0));
    drive_press(4'd5, 10, 10, 0, acks, errs, at, both);
    void'(model_press(4, 1'b0, 1'b1));
    drive_press(4'd4, 20, 10, 3, acks, errs, at, both);
    checks++;
    if (acks !== 0 || errs !== 0 || {min_tens, min_ones, sec_tens, sec_ones, digit_count} !== 19'd0) begin
      errors++;
      $display("FAIL clear_held: ack=%0d err=%0d regs=%h cnt=%0d required no pulse, all zero",
               acks, errs, {min_tens, min_ones, sec_tens, sec_ones}, digit_count);
    end
    void'(model_press(4, 1'b0, 1'b0));
    drive_press(4'd4, 10, 10, 0, acks, errs, at, both);
    checks++;
    if (acks !== 1 || at !== PULSE_STEP || sec_ones !== 4'd4 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL clear_repress: ack=%0d at=%0d sec_ones=%0d cnt=%0d required 1 at %0d, 4, 1",
               acks, at, sec_ones, digit_count, PULSE_STEP);
    end
    // clear sampled on the ACCEPT edge wins over the accept.
    void'(model_press(6, 1'b0, 1'b1));
    drive_press(4'd6, 10, 10, 6, acks, errs, at, both);
    checks++;
    if (acks !== 0 || errs !== 0 || {min_tens, min_ones, sec_tens, sec_ones, digit_count} !== 19'd0) begin
      errors++;
      $display("FAIL clear_at_accept: ack=%0d err=%0d regs=%h cnt=%0d required no pulse, all zero",
               acks, errs, {min_tens, min_ones, sec_tens, sec_ones}, digit_count);
    end
    lock = 1'b1;
    void'(model_press(9, 1'b1, 1'b0));
    drive_press(4'd9, 10, 10, 0, acks, errs, at, both);
    lock = 1'b0;
    checks++;
    if (acks !== 0 || errs !== 0 || {min_tens, min_ones, sec_tens, sec_ones, digit_count} !== {exp_word(), 3'(mq.size())}) begin
      errors++;
      $display("FAIL lock: ack=%0d err=%0d regs=%h cnt=%0d required no pulse, %h/%0d",
               acks, errs, {min_tens, min_ones, sec_tens, sec_ones}, digit_count, exp_word(), mq.size());
    end
  endtask

  task automatic test_range();
    int acks, errs, at, both, a2, e2;
    do_clear();
    void'(model_press(7, 1'b0, 1'b0));
    drive_press(4'd7, 10, 10, 0, acks, errs, at, both);
    void'(model_press(8, 1'b0, 1'b0));
    drive_press(4'd8, 10, 10, 0, a2, e2, at, both);
`ifdef SEC_RANGE_CHECK_EN
    checks++;
    if (acks !== 1 || a2 !== 0 || e2 !== 1 || sec_tens !== 4'd0 || sec_ones !== 4'd7) begin
      errors++;
      $display("FAIL range_78: acks=%0d/%0d err2=%0d sec=%0d%0d required 1/0 err2=1 sec=07",
               acks, a2, e2, sec_tens, sec_ones);
    end
`else
    checks++;
    if (acks !== 1 || a2 !== 1 || e2 !== 0 || sec_tens !== 4'd7 || sec_ones !== 4'd8) begin
      errors++;
      $display("FAIL range_78: acks=%0d/%0d err2=%0d sec=%0d%0d required 1/1 err2=0 sec=78",
               acks, a2, e2, sec_tens, sec_ones);
    end
`endif
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones, digit_count} !== {exp_word(), 3'(mq.size())}) begin
      errors++;
      $display("FAIL range_regs: got %h/%0d required %h/%0d",
               {min_tens, min_ones, sec_tens, sec_ones}, digit_count, exp_word(), mq.size());
    end
  endtask

  task automatic test_rst_midpress();
    int acks, at;
    digit = 4'd3;
    key_n = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones, digit_count, entry_valid, key_ack, key_err} !== 22'd0) begin
      errors++;
      $display("FAIL rst_mid: got %h required 0",
               {min_tens, min_ones, sec_tens, sec_ones, digit_count, entry_valid, key_ack, key_err});
    end
    rst = 1'b0;
    acks = 0; at = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (key_ack) begin acks++; if (at < 0) at = i; end
    end
    key_n = 1'b1;
    repeat (10) step();
    mq.delete();
    void'(model_press(3, 1'b0, 1'b0));
    checks++;
    if (acks !== 1 || at !== PULSE_STEP || {min_tens, min_ones, sec_tens, sec_ones} !== exp_word()) begin
      errors++;
      $display("FAIL rst_mid_reaccept: acks=%0d at=%0d regs=%h required 1 at %0d regs=%h",
               acks, at, {min_tens, min_ones, sec_tens, sec_ones}, PULSE_STEP, exp_word());
    end
  endtask

  task automatic test_random();
    int acks, errs, at, both, r, cs, hold, rel, ea, ee, eat;
    logic [3:0] d;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) do_clear();
      d    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      lock = ($urandom_range(0, 7) == 0);
      cs   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 6)) : 0;
      hold = int'($urandom_range(8, 25));
      rel  = int'($urandom_range(6, 14));
      r    = model_press(int'(d), lock, cs != 0);
      drive_press(d, hold, rel, cs, acks, errs, at, both);
      lock = 1'b0;
      ea  = (r == 1) ? 1 : 0;
      ee  = (r == 2) ? 1 : 0;
      eat = (r != 0) ? PULSE_STEP : -1;
      checks++;
      if (acks !== ea || errs !== ee || at !== eat || both !== 0) begin
        errors++;
        $display("FAIL rand%0d_pulses d=%0d: ack=%0d err=%0d at=%0d both=%0d required ack=%0d err=%0d at=%0d both=0",
                 n, d, acks, errs, at, both, ea, ee, eat);
      end
      checks++;
      if ({min_tens, min_ones, sec_tens, sec_ones, digit_count, entry_valid} !==
          {exp_word(), 3'(mq.size()), mq.size() != 0}) begin
        errors++;
        $display("FAIL rand%0d_regs: got %h/%0d/%b required %h/%0d",
                 n, {min_tens, min_ones, sec_tens, sec_ones}, digit_count, entry_valid, exp_word(), mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_bounce();
    test_full();
    test_clear_held();
    test_range();
    test_rst_midpress();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
